player_motion_ctrl: RTL and testbench
=====================================

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Clk  input  1  system clock, 50 MHz.
REQ-002 Reset  input  1  synchronous, active-high; sampled on rising Clk.
REQ-003 VGA_VS  input  1  VGA vertical sync, active-low, asynchronous to Clk.
REQ-004 keycode  input  8  primary USB HID keycode; 0x1A W=up, 0x04 A=left, 0x16 S=down, 0x07 D=right; any other value means no direction.
REQ-005 keycode_b  input  8  secondary keycode; 0xE1 (left shift) means the run key is held.
REQ-006 game_active  input  1  high only while the game FSM is in draw_main_game.
REQ-007 direction  output  2  facing direction: 0 down, 1 up, 2 left, 3 right.
REQ-008 charIsMoving  output  1  high while a step is in progress.
REQ-009 charIsRunning  output  1  run flag latched for the current step.
REQ-010 charMoveFrame  output  2  sprite column: 0 standing, 1 or 2 stride.
REQ-011 tileX  output  5  player tile column, range 0..19.
REQ-012 tileY  output  4  player tile row, range 0..14.
REQ-013 pixOffset  output  5  pixels travelled in the current step, range 0..15.
REQ-014 frame_tick  output  1  one-Clk pulse at each VGA_VS falling edge.

Function
REQ-015 VGA_VS shall pass through a 2-flop synchronizer; frame_tick shall assert for exactly one Clk, 3 Clk after a falling edge.
REQ-016 State and outputs shall change only on Clk edges where frame_tick=1 and game_active=1; on all other cycles everything holds.
REQ-017 States: IDLE, TURN, WALK.
REQ-018 IDLE, no direction key: hold.
REQ-019 IDLE, key direction differs from direction: load direction, clear turn counter, go to TURN.
REQ-020 IDLE, key direction equals direction, target tile inside the 20x15 map: go to WALK with pixOffset=0 and charIsRunning=(keycode_b==0xE1).
REQ-021 IDLE, target tile outside the map: stay in IDLE; direction is kept and no movement occurs.
REQ-022 TURN shall last TURN_FRAMES=4 ticks, then return to IDLE; re-evaluation happens on the next tick.
REQ-023 WALK: pixOffset shall advance by 1 per tick when walking and by 2 when running.
REQ-024 When pixOffset+increment reaches 16, the tile coordinate shall update (up: Y-1, down: Y+1, left: X-1, right: X+1), pixOffset shall become 0, and stepParity shall toggle.
REQ-025 At that same step-completing tick, if the same direction key is held and the next target is in bounds, the FSM shall stay in WALK and re-sample the run flag; otherwise it shall go to IDLE.
REQ-026 charIsMoving shall be 1 exactly when state is WALK.
REQ-027 charMoveFrame shall be 0 unless in WALK; in WALK it shall be (stepParity ? 2 : 1) for pixOffset 0..7 and 0 for pixOffset 8..15.
REQ-028 game_active low in mid-step shall freeze all state; the step resumes unchanged when game_active returns high.
REQ-029 Coordinate arithmetic shall never wrap: the bounds check of REQ-020 and REQ-025 guarantees 0<=tileX<=19 and 0<=tileY<=14.

Reset
REQ-030 Reset shall set: state IDLE, direction 0, tileX 10, tileY 7, pixOffset 0, stepParity 0, charIsRunning 0, turn counter 0, synchronizer flops 1.
REQ-031 Reset asserted mid-step shall abandon the step immediately, with no tile update.
REQ-032 After Reset deasserts, the first frame_tick shall not occur until a genuine VGA_VS falling edge has been seen.

Structure
REQ-033 Package pokemon_pkg shall hold: the key constants (W, A, S, D, SHIFT), the direction enum, MAP_W=20, MAP_H=15, TILE_PX=16, TURN_FRAMES=4, and the motion state enum.
REQ-034 The synchronizer and edge detector shall be a separate sub-module, vs_tick_gen; the remaining logic is a single FSM in player_motion_ctrl.

Verification
REQ-035 Reset, then hold S (0x16) for 16 ticks -> direction stays 0 and WALK is entered; after 16 ticks tileY=8, pixOffset=0, and charMoveFrame sequence is 1 x8 then 0 x8.
REQ-036 Hold D with keycode_b=0xE1 -> charIsRunning=1, pixOffset steps 0,2,4..14; tileX becomes 11 after 8 ticks.
REQ-037 From reset, press A for 1 tick -> direction=2 and TURN lasts 4 ticks with tileX still 10; a further held A then steps left.
REQ-038 Place the player at tileX=19 facing right and hold D -> state stays IDLE, charIsMoving=0, and tileX remains 19.
REQ-039 Hold W through 2 steps -> no IDLE gap between steps; stride frames go 1 on the first step and 2 on the second; tileY goes 7 -> 6 -> 5.
REQ-040 Assert Reset at pixOffset=6 -> the next Clk shows state IDLE, pixOffset 0, tileX/Y at 10/7; also, game_active low for 5 ticks mid-step -> pixOffset is frozen.

Source files
------------

// File: rtl/pokemon_pkg.sv
// -----------------------------------------------------------------------------
// pokemon_pkg
// Shared constants and types for the overworld player motion logic:
//   - USB HID keycodes for the movement keys and the run (left shift) key
//   - map geometry (tiles) and tile size (pixels)
//   - facing-direction and motion-state enums
//   - key decoder and map-bounds helper functions
// -----------------------------------------------------------------------------
package pokemon_pkg;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SHIFT = 8'hE1;

   localparam int MAP_W       = 20;
   localparam int MAP_H       = 15;
   localparam int TILE_PX     = 16;
   localparam int TURN_FRAMES = 4;
   localparam int TURN_W      = $clog2(TURN_FRAMES);

   localparam logic [4:0] START_X = 5'd10;
   localparam logic [3:0] START_Y = 4'd7;

   // Encodings match the sprite-sheet row order used by the renderer.
   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TURN = 2'd1,
      ST_WALK = 2'd2
   } motion_state_t;

   typedef struct packed {
      logic valid;
      dir_t dir;
   } key_dir_t;

   function automatic key_dir_t decode_key(input logic [7:0] kc);
      key_dir_t k;
      k.valid = 1'b1;
      k.dir   = DIR_DOWN;
      case (kc)
         KEY_W:   k.dir = DIR_UP;
         KEY_A:   k.dir = DIR_LEFT;
         KEY_S:   k.dir = DIR_DOWN;
         KEY_D:   k.dir = DIR_RIGHT;
         default: k.valid = 1'b0;
      endcase
      return k;
   endfunction

   // True when the tile adjacent to (x, y) in direction d lies on the map.
   function automatic logic target_in_map(input logic [4:0] x, input logic [3:0] y,
                                          input dir_t d);
      logic ok;
      ok = 1'b0;
      case (d)
         DIR_UP:    ok = (y != 4'd0);
         DIR_DOWN:  ok = (y < 4'(MAP_H - 1));
         DIR_LEFT:  ok = (x != 5'd0);
         DIR_RIGHT: ok = (x < 5'(MAP_W - 1));
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/vs_tick_gen.sv
// -----------------------------------------------------------------------------
// vs_tick_gen
// Brings the asynchronous, active-low VGA vertical sync into the Clk domain and
// emits a single-cycle pulse per falling edge (one pulse per video frame).
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high
//   VGA_VS     in   vertical sync, active-low, asynchronous to Clk
//   frame_tick out  one-Clk pulse, registered, 3 Clk after a VGA_VS fall
// -----------------------------------------------------------------------------
module vs_tick_gen (
   input  logic Clk,
   input  logic Reset,
   input  logic VGA_VS,
   output logic frame_tick
);

   logic sync0;
   logic sync1;
   logic sync1_d;

   // Flops reset high (the sync idle level) so leaving reset never looks like
   // a falling edge by itself.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync0      <= 1'b1;
         sync1      <= 1'b1;
         sync1_d    <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make each flop sample the previous
         // stage's old value; blocking here would collapse the chain to one flop.
         sync0      <= VGA_VS;
         sync1      <= sync0;
         sync1_d    <= sync1;
         frame_tick <= sync1_d & ~sync1;
      end
   end

endmodule

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Tile-based player movement: turning in place, walking or running one tile at
// a time, one pixel (walk) or two pixels (run) per video frame.
// Ports:
//   Clk, Reset      in   system clock; synchronous active-high reset
//   VGA_VS          in   vertical sync (async, active-low), frame time base
//   keycode         in   [7:0] primary HID keycode (W/A/S/D)
//   keycode_b       in   [7:0] secondary keycode (left shift = run)
//   game_active     in   high while the main game screen is drawn
//   direction       out  [1:0] facing direction (dir_t encoding)
//   charIsMoving    out  high while a step is in progress
//   charIsRunning   out  run flag latched for the current step
//   charMoveFrame   out  [1:0] sprite column: 0 stand, 1/2 stride
//   tileX, tileY    out  [4:0]/[3:0] player tile position
//   pixOffset       out  [4:0] pixels travelled in the current step
//   frame_tick      out  one-Clk pulse per frame
// -----------------------------------------------------------------------------
module player_motion_ctrl
   import pokemon_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       VGA_VS,
   input  logic [7:0] keycode,
   input  logic [7:0] keycode_b,
   input  logic       game_active,
   output logic [1:0] direction,
   output logic       charIsMoving,
   output logic       charIsRunning,
   output logic [1:0] charMoveFrame,
   output logic [4:0] tileX,
   output logic [3:0] tileY,
   output logic [4:0] pixOffset,
   output logic       frame_tick
);

   motion_state_t     state_q, state_d;
   dir_t              dir_q, dir_d;
   logic [4:0]        x_q, x_d;
   logic [3:0]        y_q, y_d;
   logic [4:0]        pix_q, pix_d;
   logic              parity_q, parity_d;
   logic              run_q, run_d;
   logic [TURN_W-1:0] turn_q, turn_d;

   key_dir_t          key;
   logic              run_key;
   logic              advance;
   logic [5:0]        pix_sum;
   logic [4:0]        step_x;
   logic [3:0]        step_y;

   vs_tick_gen u_vs_tick_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .VGA_VS     (VGA_VS),
      .frame_tick (frame_tick)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_DOWN;
         x_q      <= START_X;
         y_q      <= START_Y;
         pix_q    <= '0;
         parity_q <= 1'b0;
         run_q    <= 1'b0;
         turn_q   <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         x_q      <= x_d;
         y_q      <= y_d;
         pix_q    <= pix_d;
         parity_q <= parity_d;
         run_q    <= run_d;
         turn_q   <= turn_d;
      end
   end

   always_comb begin
      // NOTE: every next-state variable takes its held value first, so paths
      // that do not assign it keep state instead of inferring a latch.
      state_d  = state_q;
      dir_d    = dir_q;
      x_d      = x_q;
      y_d      = y_q;
      pix_d    = pix_q;
      parity_d = parity_q;
      run_d    = run_q;
      turn_d   = turn_q;

      key     = decode_key(keycode);
      run_key = (keycode_b == KEY_SHIFT);
      advance = frame_tick & game_active;
      pix_sum = {1'b0, pix_q} + (run_q ? 6'd2 : 6'd1);

      // Tile one step ahead of the facing direction; only committed from WALK,
      // which is entered only after the bounds check, so it never wraps.
      step_x = x_q;
      step_y = y_q;
      case (dir_q)
         DIR_UP:    step_y = y_q - 4'd1;
         DIR_DOWN:  step_y = y_q + 4'd1;
         DIR_LEFT:  step_x = x_q - 5'd1;
         DIR_RIGHT: step_x = x_q + 5'd1;
         default:   ;
      endcase

      if (advance) begin
         case (state_q)
            ST_IDLE: begin
               if (key.valid) begin
                  if (key.dir != dir_q) begin
                     dir_d   = key.dir;
                     turn_d  = '0;
                     state_d = ST_TURN;
                  end else if (target_in_map(x_q, y_q, dir_q)) begin
                     state_d = ST_WALK;
                     pix_d   = '0;
                     run_d   = run_key;
                  end
               end
            end

            ST_TURN: begin
               if (turn_q == TURN_W'(TURN_FRAMES - 1)) begin
                  turn_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  turn_d = turn_q + 1'b1;
               end
            end

            ST_WALK: begin
               if (pix_sum >= 6'(TILE_PX)) begin
                  x_d      = step_x;
                  y_d      = step_y;
                  pix_d    = '0;
                  parity_d = ~parity_q;
                  // Chain straight into the next step so there is no standing
                  // frame between tiles while the key stays down.
                  if (key.valid && (key.dir == dir_q) &&
                      target_in_map(step_x, step_y, dir_q)) begin
                     run_d = run_key;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  pix_d = pix_sum[4:0];
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign direction     = dir_q;
   assign charIsMoving  = (state_q == ST_WALK);
   assign charIsRunning = run_q;
   assign tileX         = x_q;
   assign tileY         = y_q;
   assign pixOffset     = pix_q;
   // Stride sprite shows for the first half of a step; alternating steps use
   // the left/right stride columns.
   assign charMoveFrame = (state_q == ST_WALK && !pix_q[3]) ?
                          (parity_q ? 2'd2 : 2'd1) : 2'd0;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_motion_ctrl
// Self-checking bench for player_motion_ctrl. Each frame is produced by a real
// VGA_VS falling edge; the expected outputs for that frame are queued when the
// inputs are driven and compared after the frame's update edge.
// -----------------------------------------------------------------------------
module tb_player_motion_ctrl;
   import pokemon_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       VGA_VS;
   logic [7:0] keycode;
   logic [7:0] keycode_b;
   logic       game_active;
   logic [1:0] direction;
   logic       charIsMoving;
   logic       charIsRunning;
   logic [1:0] charMoveFrame;
   logic [4:0] tileX;
   logic [3:0] tileY;
   logic [4:0] pixOffset;
   logic       frame_tick;

   typedef struct {
      int dir;
      int mv;
      int run;
      int fr;
      int x;
      int y;
      int pix;
   } exp_t;

   typedef struct {
      logic [7:0] kc;
      logic [7:0] kb;
      logic       ga;
      exp_t       e;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   vec_t vecs[8];

   player_motion_ctrl dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .VGA_VS        (VGA_VS),
      .keycode       (keycode),
      .keycode_b     (keycode_b),
      .game_active   (game_active),
      .direction     (direction),
      .charIsMoving  (charIsMoving),
      .charIsRunning (charIsRunning),
      .charMoveFrame (charMoveFrame),
      .tileX         (tileX),
      .tileY         (tileY),
      .pixOffset     (pixOffset),
      .frame_tick    (frame_tick)
   );

   always #10 Clk = ~Clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int dir, input int mv, input int run, input int fr,
                               input int x, input int y, input int pix);
      exp_t e;
      e.dir = dir; e.mv = mv; e.run = run; e.fr = fr; e.x = x; e.y = y; e.pix = pix;
      return e;
   endfunction

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard: output produced with no expectation queued");
         return;
      end
      e = exp_q.pop_front();
      check("direction",     int'(direction),     e.dir);
      check("charIsMoving",  int'(charIsMoving),  e.mv);
      check("charIsRunning", int'(charIsRunning), e.run);
      check("charMoveFrame", int'(charMoveFrame), e.fr);
      check("tileX",         int'(tileX),         e.x);
      check("tileY",         int'(tileY),         e.y);
      check("pixOffset",     int'(pixOffset),     e.pix);
   endtask

   // One frame: drive inputs, queue expectation, pull VGA_VS low, wait for the
   // tick, sample after the update edge, then restore VGA_VS high.
   task automatic do_tick(input logic [7:0] kc, input logic [7:0] kb, input logic ga,
                          input exp_t e);
      int   n;
      exp_t dropped;
      keycode     = kc;
      keycode_b   = kb;
      game_active = ga;
      exp_q.push_back(e);
      @(negedge Clk);
      VGA_VS = 1'b0;
      n = 0;
      while (!frame_tick && n < 10) begin
         @(negedge Clk);
         n++;
      end
      if (!frame_tick) begin
         checks++;
         failures++;
         $display("FAIL frame_tick_timeout: no tick within 10 Clk of VGA_VS fall");
         dropped = exp_q.pop_front();
      end else begin
         @(posedge Clk);
         #1;
         compare_out();
      end
      VGA_VS = 1'b1;
      repeat (4) @(negedge Clk);
   endtask

   // Frames of an in-progress step, pixOffset from first to last by inc.
   task automatic walk_span(input logic [7:0] kc, input logic [7:0] kb, input int dir,
                            input int run, input int parity, input int x, input int y,
                            input int first, input int last, input int inc);
      for (int p = first; p <= last; p += inc)
         do_tick(kc, kb, 1'b1,
                 mk(dir, 1, run, (p < 8) ? (parity ? 2 : 1) : 0, x, y, p));
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset       = 1'b1;
      VGA_VS      = 1'b1;
      game_active = 1'b0;
      keycode     = 8'h00;
      keycode_b   = 8'h00;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   initial begin
      int par;
      int nx;
      int mv;

      // Turn left, then walk left; includes a frozen frame (game_active low).
      vecs[0] = '{KEY_A, 8'h00, 1'b1, mk(2, 0, 0, 0, 10, 7, 0)};
      vecs[1] = '{KEY_A, 8'h00, 1'b1, mk(2, 0, 0, 0, 10, 7, 0)};
      vecs[2] = '{KEY_A, 8'h00, 1'b1, mk(2, 0, 0, 0, 10, 7, 0)};
      vecs[3] = '{KEY_A, 8'h00, 1'b1, mk(2, 0, 0, 0, 10, 7, 0)};
      vecs[4] = '{KEY_A, 8'h00, 1'b1, mk(2, 0, 0, 0, 10, 7, 0)};
      vecs[5] = '{KEY_A, 8'h00, 1'b1, mk(2, 1, 0, 1, 10, 7, 0)};
      vecs[6] = '{KEY_A, 8'h00, 1'b0, mk(2, 1, 0, 1, 10, 7, 0)};
      vecs[7] = '{8'h00, 8'h00, 1'b1, mk(2, 1, 0, 1, 10, 7, 1)};

      Reset = 1'b1; VGA_VS = 1'b1; game_active = 1'b0; keycode = 8'h00; keycode_b = 8'h00;
      do_reset();

      // Reset state.
      check("rst_direction", int'(direction), 0);
      check("rst_moving",    int'(charIsMoving), 0);
      check("rst_running",   int'(charIsRunning), 0);
      check("rst_frame",     int'(charMoveFrame), 0);
      check("rst_tileX",     int'(tileX), 10);
      check("rst_tileY",     int'(tileY), 7);
      check("rst_pix",       int'(pixOffset), 0);
      check("rst_tick",      int'(frame_tick), 0);

      // frame_tick latency and width: VGA_VS falls just before edge 1.
      @(negedge Clk);
      VGA_VS = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge Clk);
         #1;
         check($sformatf("tick_after_edge%0d", k), int'(frame_tick), (k == 3) ? 1 : 0);
      end
      VGA_VS = 1'b1;
      repeat (4) @(negedge Clk);

      // Turn, then walk left one tile.
      for (int i = 0; i < 8; i++) do_tick(vecs[i].kc, vecs[i].kb, vecs[i].ga, vecs[i].e);
      walk_span(8'h00, 8'h00, 2, 0, 0, 10, 7, 2, 15, 1);
      do_tick(8'h00, 8'h00, 1'b1, mk(2, 0, 0, 0, 9, 7, 0));

      // Walk down one tile; nothing moves between frames.
      do_reset();
      do_tick(KEY_S, 8'h00, 1'b1, mk(0, 1, 0, 1, 10, 7, 0));
      repeat (20) @(negedge Clk);
      check("hold_without_tick_pix", int'(pixOffset), 0);
      walk_span(KEY_S, 8'h00, 0, 0, 0, 10, 7, 1, 15, 1);
      do_tick(8'h00, 8'h00, 1'b1, mk(0, 0, 0, 0, 10, 8, 0));

      // Two chained steps up with alternating stride frames.
      do_reset();
      for (int i = 0; i < 5; i++) do_tick(KEY_W, 8'h00, 1'b1, mk(1, 0, 0, 0, 10, 7, 0));
      do_tick(KEY_W, 8'h00, 1'b1, mk(1, 1, 0, 1, 10, 7, 0));
      walk_span(KEY_W, 8'h00, 1, 0, 0, 10, 7, 1, 15, 1);
      do_tick(KEY_W, 8'h00, 1'b1, mk(1, 1, 0, 2, 10, 6, 0));
      walk_span(KEY_W, 8'h00, 1, 0, 1, 10, 6, 1, 15, 1);
      do_tick(8'h00, 8'h00, 1'b1, mk(1, 0, 0, 0, 10, 5, 0));

      // Run right to the east edge, then push against it.
      do_reset();
      for (int i = 0; i < 5; i++) do_tick(KEY_D, KEY_SHIFT, 1'b1, mk(3, 0, 0, 0, 10, 7, 0));
      do_tick(KEY_D, KEY_SHIFT, 1'b1, mk(3, 1, 1, 1, 10, 7, 0));
      par = 0;
      for (int x = 10; x <= 18; x++) begin
         walk_span(KEY_D, KEY_SHIFT, 3, 1, par, x, 7, 2, 14, 2);
         par = par ^ 1;
         nx  = x + 1;
         mv  = (nx < 19) ? 1 : 0;
         do_tick(KEY_D, KEY_SHIFT, 1'b1,
                 mk(3, mv, 1, (mv != 0) ? (par ? 2 : 1) : 0, nx, 7, 0));
      end
      for (int i = 0; i < 3; i++) do_tick(KEY_D, 8'h00, 1'b1, mk(3, 0, 1, 0, 19, 7, 0));

      // Freeze mid-step, then reset mid-step.
      do_reset();
      do_tick(KEY_S, 8'h00, 1'b1, mk(0, 1, 0, 1, 10, 7, 0));
      walk_span(KEY_S, 8'h00, 0, 0, 0, 10, 7, 1, 6, 1);
      for (int i = 0; i < 5; i++) do_tick(KEY_S, 8'h00, 1'b0, mk(0, 1, 0, 1, 10, 7, 6));
      do_tick(KEY_S, 8'h00, 1'b1, mk(0, 1, 0, 1, 10, 7, 7));
      walk_span(KEY_S, 8'h00, 0, 0, 0, 10, 7, 8, 9, 1);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      check("midstep_rst_moving", int'(charIsMoving), 0);
      check("midstep_rst_pix",    int'(pixOffset), 0);
      check("midstep_rst_tileX",  int'(tileX), 10);
      check("midstep_rst_tileY",  int'(tileY), 7);
      check("midstep_rst_frame",  int'(charMoveFrame), 0);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      do_tick(KEY_S, 8'h00, 1'b1, mk(0, 1, 0, 1, 10, 7, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
